// File: rtl/pop_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pop_mode_sequencer
// Description : Operating-mode controller between the POPtimers block and the
//               output pins. Debounces the raw mode button, cycles through
//               N_MODES operating modes, registers pump/probe/MW/sample/LED
//               pin drives from a per-mode table and gates the ADC trigger
//               with the synchronised MW_invalid flag.
// Config      : `define MODE_DOWN_EN adds an independently debounced
//               mode_down_n button that steps the mode backwards.
// Ports       : clk_2M5        2.5 MHz system clock
//               reset          synchronous, active-high
//               mode_button_n  raw mode-up button, active low, async
//               mode_down_n    raw mode-down button (MODE_DOWN_EN only)
//               laser_tuning   async level, synchronised internally
//               MW_invalid     async level, synchronised internally
//               pop_pump/probe/MW/sample  POP timing, already clk_2M5 domain
//               mode           current operating mode
//               pump_out/probe_out/MW_out/sample_out/LED_out  pin drives
//               ADC_sample     pop_sample gated by MW_invalid
//               reset_timers   POPtimers reset, low while MW_invalid
// Revision    : 1.0 - initial release
// ============================================================================
module pop_mode_sequencer #(
    parameter int N_MODES        = 8,
    parameter int MODE_W         = 3,
    parameter int DEBOUNCE_TICKS = 250,
    parameter int LED_CNT_W      = 21
) (
    input  logic              clk_2M5,
    input  logic              reset,
    input  logic              mode_button_n,
`ifdef MODE_DOWN_EN
    input  logic              mode_down_n,
`endif
    input  logic              laser_tuning,
    input  logic              MW_invalid,
    input  logic              pop_pump,
    input  logic              pop_probe,
    input  logic              pop_MW,
    input  logic              pop_sample,
    output logic [MODE_W-1:0] mode,
    output logic              pump_out,
    output logic              probe_out,
    output logic              MW_out,
    output logic              sample_out,
    output logic              LED_out,
    output logic              ADC_sample,
    output logic              reset_timers
);

    localparam logic [15:0]       c_DB_LAST = 16'(DEBOUNCE_TICKS - 1);
    localparam logic [MODE_W-1:0] c_LAST    = MODE_W'(N_MODES - 1);
    localparam logic [MODE_W-1:0] c_ONE     = MODE_W'(1);

    // ------------------------------------------------------------------
    // Up-button debouncer. Debounced state 1 = released.
    // ------------------------------------------------------------------
    logic        r_up_s1, r_up_s2, r_up_state;
    logic [15:0] r_up_cnt;
    logic        w_up_diff, w_up_done, w_up_press;

    assign w_up_diff  = (r_up_s2 != r_up_state);
    assign w_up_done  = w_up_diff && (r_up_cnt == c_DB_LAST);
    // Only the released->pressed transition counts as an event.
    assign w_up_press = w_up_done && !r_up_s2;

    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            r_up_s1    <= 1'b1;
            r_up_s2    <= 1'b1;
            r_up_state <= 1'b1;
            r_up_cnt   <= 16'd0;
        end else begin
            r_up_s1 <= mode_button_n;
            r_up_s2 <= r_up_s1;
            if (!w_up_diff) begin
                r_up_cnt <= 16'd0;
            end else if (w_up_done) begin
                r_up_state <= r_up_s2;
                r_up_cnt   <= 16'd0;
            end else begin
                r_up_cnt <= r_up_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional down-button debouncer, same structure as the up button.
    // ------------------------------------------------------------------
    logic w_dn_press;
`ifdef MODE_DOWN_EN
    logic        r_dn_s1, r_dn_s2, r_dn_state;
    logic [15:0] r_dn_cnt;
    logic        w_dn_diff, w_dn_done;

    assign w_dn_diff  = (r_dn_s2 != r_dn_state);
    assign w_dn_done  = w_dn_diff && (r_dn_cnt == c_DB_LAST);
    assign w_dn_press = w_dn_done && !r_dn_s2;

    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            r_dn_s1    <= 1'b1;
            r_dn_s2    <= 1'b1;
            r_dn_state <= 1'b1;
            r_dn_cnt   <= 16'd0;
        end else begin
            r_dn_s1 <= mode_down_n;
            r_dn_s2 <= r_dn_s1;
            if (!w_dn_diff) begin
                r_dn_cnt <= 16'd0;
            end else if (w_dn_done) begin
                r_dn_state <= r_dn_s2;
                r_dn_cnt   <= 16'd0;
            end else begin
                r_dn_cnt <= r_dn_cnt + 16'd1;
            end
        end
    end
`else
    assign w_dn_press = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Mode register. Simultaneous up and down events cancel out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            mode <= '0;
        end else if (w_up_press && !w_dn_press) begin
            mode <= (mode == c_LAST) ? '0 : mode + c_ONE;
        end else if (w_dn_press && !w_up_press) begin
            mode <= (mode == '0) ? c_LAST : mode - c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Level synchronisers. These reset to the inactive level so the
    // POPtimers come out of reset running on the first edge.
    // ------------------------------------------------------------------
    logic r_lt_s1, r_lt_s2, r_mw_s1, r_mw_s2;

    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            r_lt_s1 <= 1'b0;
            r_lt_s2 <= 1'b0;
            r_mw_s1 <= 1'b0;
            r_mw_s2 <= 1'b0;
        end else begin
            r_lt_s1 <= laser_tuning;
            r_lt_s2 <= r_lt_s1;
            r_mw_s1 <= MW_invalid;
            r_mw_s2 <= r_mw_s1;
        end
    end

    // ------------------------------------------------------------------
    // Free-running LED blink counter.
    // ------------------------------------------------------------------
    logic [LED_CNT_W-1:0] r_led_cnt;
    logic                 w_slow, w_medium, w_fast;

    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            r_led_cnt <= '0;
        end else begin
            r_led_cnt <= r_led_cnt + LED_CNT_W'(1);
        end
    end

    assign w_slow   = r_led_cnt[LED_CNT_W-1];
    assign w_medium = r_led_cnt[LED_CNT_W-2];
    assign w_fast   = r_led_cnt[LED_CNT_W-4];

    // ------------------------------------------------------------------
    // Per-mode output table.
    // ------------------------------------------------------------------
    logic w_led, w_pump, w_probe, w_mw, w_sample;

    always_comb begin
        w_led    = 1'b0;
        w_pump   = 1'b0;
        w_probe  = 1'b0;
        w_mw     = 1'b0;
        w_sample = 1'b0;
        case (mode)
            MODE_W'(0): begin   // POP with laser-tuning override
                w_led    = r_lt_s2;
                w_pump   = pop_pump & ~r_lt_s2;
                w_probe  = pop_probe | r_lt_s2;
                w_mw     = pop_MW & ~r_lt_s2;
                w_sample = pop_sample;
            end
            MODE_W'(1): begin   // Tune
                w_led    = w_slow;
                w_probe  = 1'b1;
                w_sample = 1'b1;
            end
            MODE_W'(2): begin   // POP
                w_led    = 1'b1;
                w_pump   = pop_pump;
                w_probe  = pop_probe;
                w_mw     = pop_MW;
                w_sample = pop_sample;
            end
            MODE_W'(3): begin   // Dark
                w_led    = w_fast;
                w_sample = 1'b1;
            end
            MODE_W'(4): begin   // Pump calibration
                w_pump   = 1'b1;
            end
            MODE_W'(5): begin   // DR
                w_led    = w_slow & w_fast;
                w_probe  = 1'b1;
                w_mw     = 1'b1;
                w_sample = 1'b1;
            end
            MODE_W'(6): begin   // Pulsed MW
                w_led    = w_slow | w_fast;
                w_probe  = 1'b1;
                w_mw     = w_slow;
                w_sample = 1'b1;
            end
            MODE_W'(7): begin   // POP bypass
                w_led    = w_slow & w_medium & w_fast;
                w_pump   = pop_pump;
                w_probe  = pop_probe;
                w_mw     = pop_MW;
                w_sample = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            pump_out     <= 1'b0;
            probe_out    <= 1'b0;
            MW_out       <= 1'b0;
            sample_out   <= 1'b0;
            LED_out      <= 1'b0;
            ADC_sample   <= 1'b0;
            reset_timers <= 1'b0;
        end else begin
            pump_out     <= w_pump;
            probe_out    <= w_probe;
            MW_out       <= w_mw;
            sample_out   <= w_sample;
            LED_out      <= w_led;
            ADC_sample   <= pop_sample & ~r_mw_s2;
            reset_timers <= ~r_mw_s2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pop_mode_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pop_mode_sequencer
// Description : Directed self-checking bench for pop_mode_sequencer with
//               DEBOUNCE_TICKS=4 and LED_CNT_W=6. Inputs change 1 ns after
//               a rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pop_mode_sequencer;

    localparam int c_DB = 4;

    logic       clk_2M5 = 1'b0;
    logic       reset = 1'b1;
    logic       mode_button_n = 1'b1;
`ifdef MODE_DOWN_EN
    logic       mode_down_n = 1'b1;
`endif
    logic       laser_tuning = 1'b0;
    logic       MW_invalid = 1'b0;
    logic       pop_pump = 1'b0;
    logic       pop_probe = 1'b0;
    logic       pop_MW = 1'b0;
    logic       pop_sample = 1'b0;
    logic [2:0] mode;
    logic       pump_out, probe_out, MW_out, sample_out, LED_out;
    logic       ADC_sample, reset_timers;

    int tests_run = 0;
    int tests_failed = 0;

    pop_mode_sequencer #(
        .N_MODES        (8),
        .MODE_W         (3),
        .DEBOUNCE_TICKS (c_DB),
        .LED_CNT_W      (6)
    ) dut (
        .clk_2M5       (clk_2M5),
        .reset         (reset),
        .mode_button_n (mode_button_n),
`ifdef MODE_DOWN_EN
        .mode_down_n   (mode_down_n),
`endif
        .laser_tuning  (laser_tuning),
        .MW_invalid    (MW_invalid),
        .pop_pump      (pop_pump),
        .pop_probe     (pop_probe),
        .pop_MW        (pop_MW),
        .pop_sample    (pop_sample),
        .mode          (mode),
        .pump_out      (pump_out),
        .probe_out     (probe_out),
        .MW_out        (MW_out),
        .sample_out    (sample_out),
        .LED_out       (LED_out),
        .ADC_sample    (ADC_sample),
        .reset_timers  (reset_timers)
    );

    always #5 clk_2M5 = ~clk_2M5;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_2M5);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mode_button_n = 1'b1;
`ifdef MODE_DOWN_EN
        mode_down_n = 1'b1;
`endif
        laser_tuning = 1'b0;
        MW_invalid = 1'b0;
        {pop_pump, pop_probe, pop_MW, pop_sample} = 4'b0000;
        tick(3);
        reset = 1'b0;
    endtask

    // Full press: mode moves on the (DB+2)-th edge, then a full release.
    task automatic press_up();
        mode_button_n = 1'b0;
        tick(c_DB + 2);
        mode_button_n = 1'b1;
        tick(c_DB + 4);
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        do_reset();
        reset = 1'b1;
        tick(3);
        outs = {pump_out, probe_out, MW_out, sample_out, LED_out, ADC_sample, reset_timers};
        tests_run++;
        if (mode !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mode: got %0d expected 0", mode);
        end
        tests_run++;
        if (outs !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000000", outs);
        end
        reset = 1'b0;
        tick(1);
        tests_run++;
        if (reset_timers !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_timers_release: got %b expected 1", reset_timers);
        end
    endtask

    task automatic test_press_latency();
        do_reset();
        tick(2);
        mode_button_n = 1'b0;   // first sampled at the next edge (k)
        tick(c_DB + 1);         // edge k+4
        tests_run++;
        if (mode !== 3'd0) begin
            tests_failed++;
            $display("FAIL latency_early: got %0d expected 0", mode);
        end
        tick(1);                // edge k+5
        tests_run++;
        if (mode !== 3'd1) begin
            tests_failed++;
            $display("FAIL latency_mode: got %0d expected 1", mode);
        end
        tick(1);
        tests_run++;
        if ({pump_out, probe_out, sample_out} !== 3'b011) begin
            tests_failed++;
            $display("FAIL latency_outputs: got %b expected 011", {pump_out, probe_out, sample_out});
        end
        tick(12);
        tests_run++;
        if (mode !== 3'd1) begin
            tests_failed++;
            $display("FAIL held_no_repeat: got %0d expected 1", mode);
        end
        mode_button_n = 1'b1;
        tick(c_DB + 4);
        tests_run++;
        if (mode !== 3'd1) begin
            tests_failed++;
            $display("FAIL release_no_change: got %0d expected 1", mode);
        end
    endtask

    task automatic test_glitch();
        mode_button_n = 1'b0;
        tick(c_DB - 1);
        mode_button_n = 1'b1;
        tick(10);
        tests_run++;
        if (mode !== 3'd1) begin
            tests_failed++;
            $display("FAIL glitch: got %0d expected 1", mode);
        end
    endtask

    task automatic test_cycle();
        // Expected {pump, probe, sample} per mode with all POP inputs low.
        logic [2:0] exp_tab [8];
        exp_tab = '{3'b000, 3'b011, 3'b000, 3'b001, 3'b100, 3'b011, 3'b011, 3'b001};
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            press_up();
            tests_run++;
            if (mode !== 3'(i % 8)) begin
                tests_failed++;
                $display("FAIL cycle_mode: press %0d got %0d expected %0d", i, mode, i % 8);
            end
            tests_run++;
            if ({pump_out, probe_out, sample_out} !== exp_tab[i % 8]) begin
                tests_failed++;
                $display("FAIL cycle_outputs: mode %0d got %b expected %b",
                         i % 8, {pump_out, probe_out, sample_out}, exp_tab[i % 8]);
            end
            if (i == 2 || i == 4) begin
                tests_run++;
                if (LED_out !== (i == 2)) begin
                    tests_failed++;
                    $display("FAIL cycle_led: mode %0d got %b expected %b", i, LED_out, i == 2);
                end
            end
            if (i == 7) begin
                logic [7:0] pat;
                pat = 8'b1011_0010;
                for (int j = 0; j < 8; j++) begin
                    pop_pump = pat[j];
                    tick(1);
                    tests_run++;
                    if (pump_out !== pat[j] || sample_out !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL bypass_track: step %0d got pump=%b sample=%b expected pump=%b sample=1",
                                 j, pump_out, sample_out, pat[j]);
                    end
                end
                pop_pump = 1'b0;
                tick(1);
            end
        end
    endtask

    task automatic test_tune_mw();
        do_reset();
        tick(2);
        laser_tuning = 1'b1;
        pop_pump = 1'b1;
        tick(2);
        tests_run++;
        if ({pump_out, probe_out} !== 2'b10) begin
            tests_failed++;
            $display("FAIL tune_before_sync: got %b expected 10", {pump_out, probe_out});
        end
        tick(1);
        tests_run++;
        if ({pump_out, probe_out, LED_out} !== 3'b011) begin
            tests_failed++;
            $display("FAIL tune_after_sync: got %b expected 011", {pump_out, probe_out, LED_out});
        end
        laser_tuning = 1'b0;
        pop_pump = 1'b0;
        MW_invalid = 1'b1;
        tick(3);
        pop_sample = 1'b1;
        tick(1);
        tests_run++;
        if ({ADC_sample, reset_timers, sample_out} !== 3'b001) begin
            tests_failed++;
            $display("FAIL mw_invalid_gate: got %b expected 001", {ADC_sample, reset_timers, sample_out});
        end
        pop_sample = 1'b0;
        MW_invalid = 1'b0;
        tick(3);
        pop_sample = 1'b1;
        tick(1);
        tests_run++;
        if ({ADC_sample, reset_timers} !== 2'b11) begin
            tests_failed++;
            $display("FAIL mw_valid_pass: got %b expected 11", {ADC_sample, reset_timers});
        end
        pop_sample = 1'b0;
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        tick(2);
        mode_button_n = 1'b0;
        tick(c_DB - 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(c_DB - 1);
        mode_button_n = 1'b1;
        tick(10);
        tests_run++;
        if (mode !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_debounce: got %0d expected 0", mode);
        end
    endtask

`ifdef MODE_DOWN_EN
    task automatic test_mode_down();
        do_reset();
        mode_down_n = 1'b0;
        tick(c_DB + 2);
        mode_down_n = 1'b1;
        tick(c_DB + 4);
        tests_run++;
        if (mode !== 3'd7) begin
            tests_failed++;
            $display("FAIL down_wrap: got %0d expected 7", mode);
        end
        mode_down_n = 1'b0;
        mode_button_n = 1'b0;
        tick(c_DB + 2);
        mode_down_n = 1'b1;
        mode_button_n = 1'b1;
        tick(c_DB + 4);
        tests_run++;
        if (mode !== 3'd7) begin
            tests_failed++;
            $display("FAIL up_down_cancel: got %0d expected 7", mode);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_cycle();
        test_tune_mw();
        test_reset_mid_debounce();
`ifdef MODE_DOWN_EN
        test_mode_down();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
